mul_hilo_unit: RTL and testbench

Sequential 32×32 unsigned multiplier with the HI/LO register pair, sitting on the receiving end of the ALU control's MUL/MUX signal lines. It runs a shift-add multiply over 32 cycles on the MULT function code. It commits the 64-bit product into HI/LO on the control's open-HiLo strobe (6'b111111), and drives HI or LO onto the datapath for MFHI/MFLO.

---
 rtl/mul_hilo_unit_if.sv | 21 ++
 rtl/mul_hilo_unit.sv | 127 ++++++++++++
 tb/tb_mul_hilo_unit.sv | 208 ++++++++++++++++++++
 3 files changed

// File: rtl/mul_hilo_unit_if.sv
// Control/data bundle between the ALU control and the HI/LO multiplier.
interface mul_hilo_unit_if #(
    parameter int unsigned WIDTH = 32
);
    logic [5:0]       Signal;
    logic [WIDTH-1:0] dataA;
    logic [WIDTH-1:0] dataB;
    logic [WIDTH-1:0] dataOut;
    logic             busy;
    logic             done;

    modport master (
        output Signal, dataA, dataB,
        input  dataOut, busy, done
    );

    modport slave (
        input  Signal, dataA, dataB,
        output dataOut, busy, done
    );
endinterface

// File: rtl/mul_hilo_unit.sv
// Sequential unsigned shift-add multiplier with HI/LO result registers.
// A product is committed to HI/LO only on the open-HiLo strobe.
module mul_hilo_unit #(
    parameter int unsigned WIDTH = 32
) (
    input logic             clk,
    input logic             rst_n,
    mul_hilo_unit_if.slave  bus
);
    localparam int unsigned CntW = (WIDTH > 1) ? $clog2(WIDTH) : 1;

    localparam logic [5:0] OpMult = 6'b011001;
    localparam logic [5:0] OpMfhi = 6'b010000;
    localparam logic [5:0] OpMflo = 6'b010010;
    localparam logic [5:0] OpHilo = 6'b111111;

    localparam logic [1:0] StIdle = 2'd0;
    localparam logic [1:0] StRun  = 2'd1;
    localparam logic [1:0] StDone = 2'd2;

    logic [1:0]         state_q, state_d;
    logic [WIDTH-1:0]   mcand_q, mcand_d;
    logic [2*WIDTH-1:0] prod_q, prod_d;
    logic [CntW-1:0]    cnt_q, cnt_d;
    logic               pending_q, pending_d;
    logic               armed_q, armed_d;
    logic [WIDTH-1:0]   hi_q, hi_d;
    logic [WIDTH-1:0]   lo_q, lo_d;
    logic               done_q, done_d;

    // The extra sum bit is the carry that enters the product MSB on the shift.
    logic [WIDTH:0]     sum;
    logic [2*WIDTH-1:0] prod_step;

    always_comb begin
        sum       = {1'b0, prod_q[2*WIDTH-1:WIDTH]}
                  + (prod_q[0] ? {1'b0, mcand_q} : {(WIDTH+1){1'b0}});
        prod_step = {sum, prod_q[WIDTH-1:1]};
    end

    always_comb begin
        state_d   = state_q;
        mcand_d   = mcand_q;
        prod_d    = prod_q;
        cnt_d     = cnt_q;
        pending_d = pending_q;
        armed_d   = armed_q;
        hi_d      = hi_q;
        lo_d      = lo_q;
        done_d    = 1'b0;

        case (state_q)
            StIdle: begin
                // Re-arm only after Signal leaves MULT, so a held MULT cannot relaunch.
                if (bus.Signal != OpMult) begin
                    armed_d = 1'b1;
                end else if (armed_q) begin
                    mcand_d   = bus.dataA;
                    prod_d    = {{WIDTH{1'b0}}, bus.dataB};
                    cnt_d     = '0;
                    pending_d = 1'b0;
                    armed_d   = 1'b0;
                    state_d   = StRun;
                end
            end
            StRun: begin
                if (bus.Signal == OpMult || bus.Signal == OpHilo) begin
                    if (bus.Signal == OpHilo) begin
                        pending_d = 1'b1;
                    end
                    prod_d = prod_step;
                    cnt_d  = cnt_q + CntW'(1);
                    if (cnt_q == CntW'(WIDTH - 1)) begin
                        state_d = StDone;
                    end
                end else begin
                    state_d = StIdle;
                end
            end
            StDone: begin
                if (pending_q || bus.Signal == OpHilo) begin
                    hi_d    = prod_q[2*WIDTH-1:WIDTH];
                    lo_d    = prod_q[WIDTH-1:0];
                    done_d  = 1'b1;
                    state_d = StIdle;
                end
            end
            default: state_d = StIdle;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q   <= StIdle;
            mcand_q   <= '0;
            prod_q    <= '0;
            cnt_q     <= '0;
            pending_q <= 1'b0;
            armed_q   <= 1'b1;
            hi_q      <= '0;
            lo_q      <= '0;
            done_q    <= 1'b0;
        end else begin
            state_q   <= state_d;
            mcand_q   <= mcand_d;
            prod_q    <= prod_d;
            cnt_q     <= cnt_d;
            pending_q <= pending_d;
            armed_q   <= armed_d;
            hi_q      <= hi_d;
            lo_q      <= lo_d;
            done_q    <= done_d;
        end
    end

    always_comb begin
        bus.busy = (state_q == StRun);
        bus.done = done_q;
        if (bus.Signal == OpMfhi) begin
            bus.dataOut = hi_q;
        end else if (bus.Signal == OpMflo) begin
            bus.dataOut = lo_q;
        end else begin
            bus.dataOut = '0;
        end
    end
endmodule

// File: tb/tb_mul_hilo_unit.sv
// Bench for mul_hilo_unit: directed stimulus feeds expectation queues that a
// negedge monitor drains against HI/LO reads and done pulses.
module tb_mul_hilo_unit;
    localparam logic [5:0] OpMult = 6'b011001;
    localparam logic [5:0] OpMfhi = 6'b010000;
    localparam logic [5:0] OpMflo = 6'b010010;
    localparam logic [5:0] OpHilo = 6'b111111;
    localparam logic [5:0] OpAdd  = 6'b100000;
    localparam logic [5:0] OpSlt  = 6'b101010;

    logic clk;
    logic rst_n;
    int   cyc;
    int   checks;
    int   errors;
    logic rd_req;

    logic [31:0] exp_rd[$];
    int          exp_done[$];
    logic [31:0] mon_exp;
    int          mon_cyc;

    mul_hilo_unit_if #(.WIDTH(32)) bus ();

    mul_hilo_unit #(.WIDTH(32)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    always @(negedge clk) begin
        if (rd_req) begin
            checks = checks + 1;
            if (exp_rd.size() == 0) begin
                errors = errors + 1;
                $display("FAIL read_unexpected: dataOut=%h with no expectation", bus.dataOut);
            end else begin
                mon_exp = exp_rd.pop_front();
                if (bus.dataOut !== mon_exp) begin
                    errors = errors + 1;
                    $display("FAIL read sig=%b: got %h want %h", bus.Signal, bus.dataOut, mon_exp);
                end
            end
        end
        if (bus.done !== 1'b0) begin
            checks = checks + 1;
            if (exp_done.size() == 0) begin
                errors = errors + 1;
                $display("FAIL done_unexpected: done=%b at cycle %0d, want no pulse", bus.done, cyc);
            end else begin
                mon_cyc = exp_done.pop_front();
                if (mon_cyc != cyc) begin
                    errors = errors + 1;
                    $display("FAIL done_cycle: got cycle %0d want %0d", cyc, mon_cyc);
                end
            end
        end
    end

    task automatic step(input int n = 1);
        repeat (n) begin
            @(posedge clk);
            #1;
        end
    endtask

    task automatic chk(input string name, input logic [63:0] got, input logic [63:0] want);
        checks = checks + 1;
        if (got !== want) begin
            errors = errors + 1;
            $display("FAIL %s: got %h want %h", name, got, want);
        end
    endtask

    task automatic rd(input logic [5:0] s, input logic [31:0] want);
        bus.Signal = s;
        exp_rd.push_back(want);
        rd_req = 1'b1;
        step(1);
        rd_req = 1'b0;
    endtask

    task automatic launch(input logic [31:0] a, input logic [31:0] b, output int e0);
        bus.Signal = OpMult;
        bus.dataA  = a;
        bus.dataB  = b;
        step(1);
        e0 = cyc;
    endtask

    int e0;
    int busy_seen;

    initial begin
        cyc = 0;
        checks = 0;
        errors = 0;
        rd_req = 1'b0;
        rst_n = 1'b0;
        bus.Signal = OpAdd;
        bus.dataA = '0;
        bus.dataB = '0;
        step(2);
        chk("reset_busy", {63'd0, bus.busy}, 64'd0);
        chk("reset_done", {63'd0, bus.done}, 64'd0);
        chk("reset_dataOut", {32'd0, bus.dataOut}, 64'd0);
        rst_n = 1'b1;
        step(1);

        // Strobe in IDLE does nothing; non-move codes read as zero.
        bus.Signal = OpHilo;
        step(3);
        rd(OpMfhi, 32'h0);
        rd(OpMflo, 32'h0);
        rd(OpSlt, 32'h0);

        // 3 x 5 with MULT held, strobe sampled in DONE.
        launch(32'd3, 32'd5, e0);
        exp_done.push_back(e0 + 33);
        chk("t1_busy_launch", {63'd0, bus.busy}, 64'd1);
        step(31);
        chk("t1_busy_last_step", {63'd0, bus.busy}, 64'd1);
        step(1);
        chk("t1_busy_in_done", {63'd0, bus.busy}, 64'd0);
        bus.Signal = OpHilo;
        step(1);
        bus.Signal = OpAdd;
        step(1);
        rd(OpMfhi, 32'h0000_0000);
        rd(OpMflo, 32'h0000_000F);

        // 7 x 9 aborted by ADD; HI/LO must still hold 3 x 5.
        launch(32'd7, 32'd9, e0);
        step(10);
        chk("t3_busy_before_abort", {63'd0, bus.busy}, 64'd1);
        bus.Signal = OpAdd;
        step(1);
        chk("t3_busy_after_abort", {63'd0, bus.busy}, 64'd0);
        step(40);
        rd(OpMflo, 32'h0000_000F);
        rd(OpMfhi, 32'h0000_0000);

        // Max operands, early strobe latched as pending, commit with no later strobe.
        launch(32'hFFFF_FFFF, 32'hFFFF_FFFF, e0);
        exp_done.push_back(e0 + 33);
        step(10);
        bus.Signal = OpHilo;
        step(1);
        bus.Signal = OpMult;
        step(22);
        chk("t2_busy_in_done", {63'd0, bus.busy}, 64'd0);
        step(1);
        bus.Signal = OpAdd;
        step(1);
        rd(OpMfhi, 32'hFFFF_FFFE);
        rd(OpMflo, 32'h0000_0001);

        // MULT held for 80 cycles with one strobe: single commit, no relaunch.
        launch(32'd6, 32'd7, e0);
        exp_done.push_back(e0 + 33);
        busy_seen = 0;
        for (int k = 0; k < 80; k++) begin
            bus.Signal = (k == 32) ? OpHilo : OpMult;
            step(1);
            if (k >= 33 && bus.busy === 1'b1) busy_seen++;
        end
        chk("t5_no_relaunch", 64'(busy_seen), 64'd0);
        bus.Signal = OpAdd;
        step(1);
        bus.Signal = OpMult;
        step(1);
        chk("t5_relaunch_after_rearm", {63'd0, bus.busy}, 64'd1);
        bus.Signal = OpAdd;
        step(1);
        chk("t5_abort_busy", {63'd0, bus.busy}, 64'd0);
        rd(OpMfhi, 32'h0);
        rd(OpMflo, 32'd42);

        // Reset mid-run clears HI/LO at once; later strobe is ignored.
        launch(32'h1234_5678, 32'h0000_0010, e0);
        step(19);
        chk("t4_busy_before_reset", {63'd0, bus.busy}, 64'd1);
        bus.Signal = OpMflo;
        #2;
        rst_n = 1'b0;
        #1;
        chk("t4_busy_in_reset", {63'd0, bus.busy}, 64'd0);
        chk("t4_lo_in_reset", {32'd0, bus.dataOut}, 64'd0);
        step(1);
        rd(OpMfhi, 32'h0);
        rst_n = 1'b1;
        bus.Signal = OpHilo;
        step(40);
        rd(OpMflo, 32'h0);
        rd(OpMfhi, 32'h0);

        step(2);
        chk("done_queue_drained", 64'(exp_done.size()), 64'd0);
        chk("read_queue_drained", 64'(exp_rd.size()), 64'd0);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
